// File: rtl/data_mem_mmio_if.sv
// Load/store bus between the M stage of the pipelined core and its data memory.
// The core drives the strobe, address and store data; the memory returns load data.
interface data_mem_mmio_if;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_write, output addr, output write_data, input read_data);
  modport slave  (input mem_write, input addr, input write_data, output read_data);
endinterface

// File: rtl/data_mem_mmio.sv
// Data memory with a small peripheral window: GPIO, free-running cycle counter,
// compare timer with sticky hit flag, and a sticky misaligned-store flag.
module data_mem_mmio #(
  parameter int          DEPTH     = 256,
  parameter logic [15:0] MMIO_BASE = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_mmio_if.slave        bus,
  output logic [7:0]            gpio_out,
  output logic                  timer_irq,
  output logic                  misalign_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] REG_GPIO   = 6'h00;
  localparam logic [5:0] REG_CYCLE  = 6'h01;
  localparam logic [5:0] REG_CMP    = 6'h02;
  localparam logic [5:0] REG_STATUS = 6'h03;

  logic [31:0]   r_ram [DEPTH];
  logic [7:0]    r_gpio;
  logic [31:0]   r_cycle;
  logic [31:0]   r_cmp;
  logic          r_timer_hit;
  logic          r_misalign;

  logic          w_mmio_sel;
  logic          w_page_ok;
  logic [5:0]    w_reg_idx;
  logic [AW-1:0] w_ram_idx;
  logic          w_aligned;
  logic          w_wr;
  logic          w_mmio_wr;
  logic          w_ram_we;
  logic          w_we_gpio;
  logic          w_we_cycle;
  logic          w_we_cmp;
  logic          w_we_status;
  logic          w_hit_set;
  logic          w_misalign_set;
  logic [31:0]   w_rdata;

  // Address decode: loads ignore addr[1:0]; stores with nonzero addr[1:0] are dropped.
  assign w_mmio_sel = (bus.addr[31:16] == MMIO_BASE);
  assign w_page_ok  = (bus.addr[15:8] == 8'h00);
  assign w_reg_idx  = bus.addr[7:2];
  assign w_ram_idx  = bus.addr[AW+1:2];
  assign w_aligned  = (bus.addr[1:0] == 2'b00);

  assign w_wr        = bus.mem_write && w_aligned;
  assign w_mmio_wr   = w_wr && w_mmio_sel && w_page_ok;
  assign w_ram_we    = w_wr && !w_mmio_sel;
  assign w_we_gpio   = w_mmio_wr && (w_reg_idx == REG_GPIO);
  assign w_we_cycle  = w_mmio_wr && (w_reg_idx == REG_CYCLE);
  assign w_we_cmp    = w_mmio_wr && (w_reg_idx == REG_CMP);
  assign w_we_status = w_mmio_wr && (w_reg_idx == REG_STATUS);

  // Compare sees the pre-write counter value, so a same-cycle CYCLE write cannot mask a hit.
  assign w_hit_set      = (r_cycle == r_cmp) && (r_cmp != 32'h0);
  assign w_misalign_set = bus.mem_write && !w_aligned;

  // NOTE: the RAM array is never cleared; the empty reset branch only blocks writes
  // while reset is low, so contents survive a reset pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
    end else if (w_ram_we) begin
      r_ram[w_ram_idx] <= bus.write_data;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples the same pre-edge values (the compare relies on the old r_cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gpio      <= 8'h00;
      r_cycle     <= 32'h0;
      r_cmp       <= 32'h0;
      r_timer_hit <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      if (w_we_gpio) r_gpio <= bus.write_data[7:0];
      if (w_we_cycle) r_cycle <= bus.write_data;
      else            r_cycle <= r_cycle + 32'd1;
      if (w_we_cmp) r_cmp <= bus.write_data;
      // Flags are sticky and write-1-to-clear; a same-cycle set beats the clear.
      r_timer_hit <= w_hit_set
                   | (r_timer_hit & ~(w_we_status & bus.write_data[0]));
      r_misalign  <= w_misalign_set
                   | (r_misalign & ~(w_we_status & bus.write_data[1]));
    end
  end

  // NOTE: default assignment first so no path through the decode infers a latch.
  always_comb begin
    w_rdata = 32'h0;
    if (w_mmio_sel) begin
      if (w_page_ok) begin
        case (w_reg_idx)
          REG_GPIO:   w_rdata = {24'h0, r_gpio};
          REG_CYCLE:  w_rdata = r_cycle;
          REG_CMP:    w_rdata = r_cmp;
          REG_STATUS: w_rdata = {30'h0, r_misalign, r_timer_hit};
          default:    w_rdata = 32'h0;
        endcase
      end
    end else begin
      w_rdata = r_ram[w_ram_idx];
    end
  end

  assign bus.read_data = w_rdata;
  assign gpio_out      = r_gpio;
  assign timer_irq     = r_timer_hit;
  assign misalign_err  = r_misalign;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_data_mem_mmio;

  localparam logic [31:0] A_GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_0004;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic clk;
  logic reset;
  logic [7:0] gpio_out;
  logic timer_irq;
  logic misalign_err;

  int total;
  int bad;
  logic [31:0] sb [$];

  data_mem_mmio_if bus ();

  data_mem_mmio #(.DEPTH(256), .MMIO_BASE(16'hFFFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .gpio_out     (gpio_out),
    .timer_irq    (timer_irq),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  // Store: returns the same-cycle (pre-edge) load value, ends at posedge+1.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic [31:0] old);
    bus.mem_write  = 1'b1;
    bus.addr       = a;
    bus.write_data = d;
    #1 old = bus.read_data;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.mem_write = 1'b0;
    bus.addr      = a;
    #1 d = bus.read_data;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] old;
    total = 0;
    bad   = 0;
    reset          = 1'b0;
    bus.mem_write  = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;

    // Reset held for three cycles
    tick(3);
    expect_val(32'h0); check("rst_gpio", {24'h0, gpio_out});
    expect_val(32'h0); check("rst_irq", {31'h0, timer_irq});
    expect_val(32'h0); check("rst_misalign", {31'h0, misalign_err});
    rd(A_CYCLE, d);
    expect_val(32'h0); check("rst_cycle_held", d);

    reset = 1'b1;
    rd(A_CYCLE, d);
    expect_val(32'h0); check("cycle_first", d);
    tick(5);
    rd(A_CYCLE, d);
    expect_val(32'd5); check("cycle_after5", d);

    // RAM store/load, same-cycle old value, aliasing
    wr(32'h0000_0010, 32'h1111_1111, old);
    wr(32'h0000_0010, 32'hDEAD_BEEF, old);
    expect_val(32'h1111_1111); check("ram_same_cycle_old", old);
    rd(32'h0000_0010, d);
    expect_val(32'hDEAD_BEEF); check("ram_read", d);
    rd(32'h0000_0413, d);
    expect_val(32'hDEAD_BEEF); check("ram_alias", d);

    // GPIO and unmapped page
    wr(A_GPIO, 32'h1234_56A5, old);
    expect_val(32'hA5); check("gpio_out", {24'h0, gpio_out});
    rd(A_GPIO, d);
    expect_val(32'h0000_00A5); check("gpio_read", d);
    wr(32'hFFFF_0100, 32'hFFFF_FFFF, old);
    expect_val(32'hA5); check("unmapped_wr_gpio", {24'h0, gpio_out});
    rd(32'hFFFF_0100, d);
    expect_val(32'h0); check("unmapped_read", d);
    rd(32'hFFFF_0010, d);
    expect_val(32'h0); check("unmapped_offset_read", d);

    // Timer: CMP=20, CYCLE=15; hit after the edge ending the CYCLE=20 cycle
    wr(A_CMP, 32'd20, old);
    wr(A_CYCLE, 32'd15, old);
    rd(A_CMP, d);
    expect_val(32'd20); check("cmp_read", d);
    tick(5);
    rd(A_CYCLE, d);
    expect_val(32'd20); check("cycle_at_match", d);
    expect_val(32'h0); check("irq_before_match_edge", {31'h0, timer_irq});
    tick(1);
    expect_val(32'h1); check("irq_after_match", {31'h0, timer_irq});
    rd(A_STATUS, d);
    expect_val(32'h1); check("status_hit", d);
    wr(A_STATUS, 32'h1, old);
    expect_val(32'h0); check("irq_w1c", {31'h0, timer_irq});

    // W1C in the exact match cycle: set wins
    wr(A_CYCLE, 32'd17, old);
    tick(3);
    rd(A_CYCLE, d);
    expect_val(32'd20); check("cycle_match_again", d);
    wr(A_STATUS, 32'h1, old);
    expect_val(32'h1); check("irq_set_beats_w1c", {31'h0, timer_irq});
    wr(A_STATUS, 32'h1, old);
    expect_val(32'h0); check("irq_clear2", {31'h0, timer_irq});

    // Misaligned stores
    wr(32'h0000_0020, 32'hA5A5_A5A5, old);
    wr(32'h0000_0022, 32'h0000_0055, old);
    rd(32'h0000_0020, d);
    expect_val(32'hA5A5_A5A5); check("misalign_ram_unchanged", d);
    expect_val(32'h1); check("misalign_set", {31'h0, misalign_err});
    rd(A_STATUS, d);
    expect_val(32'h2); check("status_misalign", d);
    wr(A_STATUS, 32'h2, old);
    expect_val(32'h0); check("misalign_w1c", {31'h0, misalign_err});
    rd(32'h0000_0023, d);
    expect_val(32'hA5A5_A5A5); check("misaligned_load", d);
    tick(1);
    expect_val(32'h0); check("no_flag_on_load", {31'h0, misalign_err});
    wr(32'hFFFF_0001, 32'h0000_0077, old);
    expect_val(32'hA5); check("misalign_gpio_unchanged", {24'h0, gpio_out});
    expect_val(32'h1); check("misalign_set_mmio", {31'h0, misalign_err});

    // Async reset mid-run with an in-flight store
    wr(A_GPIO, 32'h0000_00FF, old);
    expect_val(32'hFF); check("gpio_ff", {24'h0, gpio_out});
    bus.mem_write  = 1'b1;
    bus.addr       = 32'h0000_0010;
    bus.write_data = 32'hBAD0_BAD0;
    #2 reset = 1'b0;
    #1;
    expect_val(32'h0); check("async_gpio", {24'h0, gpio_out});
    expect_val(32'h0); check("async_misalign", {31'h0, misalign_err});
    @(posedge clk);
    #1 bus.mem_write = 1'b0;
    reset = 1'b1;
    rd(A_CYCLE, d);
    expect_val(32'h0); check("cycle_restart", d);
    rd(32'h0000_0010, d);
    expect_val(32'hDEAD_BEEF); check("ram_preserved", d);
    tick(2);
    rd(A_CYCLE, d);
    expect_val(32'd2); check("cycle_runs_again", d);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_leftover count=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
